calc_unit_seq: RTL and testbench

//  Parametrised, handshaked successor to the 4-bit combinational calculator.

---
 rtl/calc_unit_seq_pkg.sv | 27 ++
 rtl/calc_shift_add_mul.sv | 56 +++++
 rtl/calc_unit_seq.sv | 136 +++++++++++++
 tb/tb_calc_unit_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_unit_seq_pkg.sv
// Shared types for the sequential calculator: opcode encoding, FSM states and
// a helper that flags opcodes outside the defined set.
package calc_unit_seq_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MUL = 3'd5
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Codes 6 and 7 have no operation behind them.
   function automatic logic op_reserved(input logic [OP_W-1:0] op);
      return (op > 3'd5);
   endfunction

endpackage

// File: rtl/calc_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one bit of b per cycle, LSB first,
// result available on the cycle done is high.
module calc_shift_add_mul #(
   parameter int WIDTH = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] addend;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;

   // product already includes this cycle's partial product, so the final
   // value can be captured on the same edge that retires the last bit.
   always_comb begin
      addend  = mplier[0] ? mcand : '0;
      product = acc + addend;
      done    = busy && (cnt == CNT_W'(1));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= CNT_W'(WIDTH);
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/calc_unit_seq.sv
// Handshaked calculator: single-cycle ALU ops, iterative MUL, and an output
// register that holds result/flags until the consumer takes them.
module calc_unit_seq
   import calc_unit_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  opcode_t            in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               carry,
   output logic               zero,
   output logic               err
);

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic               is_mul;
   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] alu_result;
   logic               alu_carry;
   logic               alu_err;

   assign in_ready  = reset_n && ((state == IDLE) || ((state == DONE) && out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (in_op == OP_MUL);
   assign mul_start = accept && is_mul;

   calc_shift_add_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (in_a),
      .b       (in_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle ALU; the extra top bit of sum/diff gives carry and borrow.
   always_comb begin
      sum        = {1'b0, in_a} + {1'b0, in_b};
      diff       = {1'b0, in_a} - {1'b0, in_b};
      alu_result = '0;
      alu_carry  = 1'b0;
      alu_err    = 1'b0;
      case (in_op)
         OP_ADD: begin
            alu_result = {{(WIDTH-1){1'b0}}, sum};
            alu_carry  = sum[WIDTH];
         end
         OP_SUB: begin
            alu_result = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            alu_carry  = diff[WIDTH];
         end
         OP_AND:  alu_result = {{WIDTH{1'b0}}, in_a & in_b};
         OP_OR:   alu_result = {{WIDTH{1'b0}}, in_a | in_b};
         OP_XOR:  alu_result = {{WIDTH{1'b0}}, in_a ^ in_b};
         OP_MUL:  alu_result = '0;
         default: alu_err    = op_reserved(in_op);
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = is_mul ? MUL_RUN : DONE;
            end
         end
         MUL_RUN: begin
            // A multiplier that is idle here can never finish; fall out to DONE.
            if (mul_done || !mul_busy) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (accept) begin
                  state_nxt = is_mul ? MUL_RUN : DONE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Output register: loads only on a non-MUL accept or the final MUL step,
   // so it holds while the consumer stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b0;
         err    <= 1'b0;
      end else if (accept && !is_mul) begin
         result <= alu_result;
         carry  <= alu_carry;
         zero   <= (alu_result == '0);
         err    <= alu_err;
      end else if ((state == MUL_RUN) && mul_done) begin
         result <= mul_product;
         carry  <= 1'b0;
         zero   <= (mul_product == '0);
         err    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_calc_unit_seq.sv
// Bench for calc_unit_seq: vector table, directed handshake/reset sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_calc_unit_seq;
   import calc_unit_seq_pkg::*;

   logic       clock;
   logic       reset_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [3:0] in_a, in_b;
   opcode_t    in_op;
   logic [7:0] result;
   logic       carry, zero, err;

   logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready;
   logic [7:0]  w8_in_a, w8_in_b;
   opcode_t     w8_in_op;
   logic [15:0] w8_result;
   logic        w8_carry, w8_zero, w8_err;

   int total = 0;
   int bad   = 0;

   calc_unit_seq #(.WIDTH(4)) dut4 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero), .err(err)
   );

   calc_unit_seq #(.WIDTH(8)) dut8 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(w8_in_valid), .in_ready(w8_in_ready),
      .in_a(w8_in_a), .in_b(w8_in_b), .in_op(w8_in_op),
      .out_valid(w8_out_valid), .out_ready(w8_out_ready),
      .result(w8_result), .carry(w8_carry), .zero(w8_zero), .err(w8_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int unsigned r;
      bit          c;
      bit          z;
      bit          e;
   } exp_t;

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic [2:0]  op;
      int unsigned res;
      bit          c;
      bit          z;
      bit          e;
      int          lat;
   } vec_t;

   // Reference: plain integer arithmetic from the operation definitions.
   function automatic exp_t model(input int unsigned a, input int unsigned b,
                                  input int unsigned op, input int unsigned w);
      exp_t x;
      int unsigned m;
      m   = 1 << w;
      x.r = 0; x.c = 0; x.e = 0;
      case (op)
         0: begin x.r = a + b; x.c = ((a + b) >= m); end
         1: begin x.r = (a + m - b) % m; x.c = (a < b); end
         2: x.r = a & b;
         3: x.r = a | b;
         4: x.r = a ^ b;
         5: x.r = a * b;
         default: x.e = 1;
      endcase
      x.z = (x.r == 0);
      return x;
   endfunction

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one instruction with out_ready=1, measure edges to out_valid and stall cycles.
   task automatic run_vec(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input int unsigned res, input bit c,
                          input bit z, input bit e, input int lat);
      int n;
      int stall;
      in_a = a; in_b = b; in_op = opcode_t'(op);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({name, " in_ready"}, 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      n = 0; stall = 0;
      while (!out_valid && n < 40) begin
         if (!in_ready) stall++;
         tick();
         n++;
      end
      check({name, " latency"}, 64'(n), 64'(lat));
      check({name, " stall"}, 64'(stall), 64'(lat));
      check({name, " result"}, 64'(result), 64'(res));
      check({name, " carry"}, 64'(carry), 64'(c));
      check({name, " zero"}, 64'(zero), 64'(z));
      check({name, " err"}, 64'(err), 64'(e));
   endtask

   vec_t vecs[13];

   initial begin
      exp_t        x;
      exp_t        q[$];
      exp_t        f;
      bit          hold_in, prev_hold, acc, deq;
      logic [7:0]  prev_res;
      logic [3:0]  prev_flags;
      int          n, cnt;

      vecs[0]  = '{4'd8,  4'd15, 3'd0, 23,  1, 0, 0, 0};
      vecs[1]  = '{4'd3,  4'd5,  3'd1, 14,  1, 0, 0, 0};
      vecs[2]  = '{4'd5,  4'd5,  3'd1, 0,   0, 1, 0, 0};
      vecs[3]  = '{4'd0,  4'd1,  3'd1, 15,  1, 0, 0, 0};
      vecs[4]  = '{4'd12, 4'd3,  3'd3, 15,  0, 0, 0, 0};
      vecs[5]  = '{4'd6,  4'd3,  3'd4, 5,   0, 0, 0, 0};
      vecs[6]  = '{4'd3,  4'd3,  3'd7, 0,   0, 1, 1, 0};
      vecs[7]  = '{4'd12, 4'd10, 3'd2, 8,   0, 0, 0, 0};
      vecs[8]  = '{4'd15, 4'd15, 3'd5, 225, 0, 0, 0, 4};
      vecs[9]  = '{4'd0,  4'd9,  3'd5, 0,   0, 1, 0, 4};
      vecs[10] = '{4'd9,  4'd6,  3'd6, 0,   0, 1, 1, 0};
      vecs[11] = '{4'd11, 4'd13, 3'd5, 143, 0, 0, 0, 4};
      vecs[12] = '{4'd0,  4'd0,  3'd0, 0,   0, 1, 0, 0};

      reset_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = OP_ADD;
      w8_in_valid = 1'b0; w8_out_ready = 1'b1; w8_in_a = '0; w8_in_b = '0; w8_in_op = OP_ADD;

      // Reset state
      tick(); tick();
      check("rst in_ready", 64'(in_ready), 64'(0));
      check("rst out_valid", 64'(out_valid), 64'(0));
      check("rst result", 64'(result), 64'(0));
      check("rst flags", 64'({carry, zero, err}), 64'(0));
      #2 reset_n = 1'b1;
      tick();
      check("idle in_ready", 64'(in_ready), 64'(1));

      for (int i = 0; i < 13; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res,
                 vecs[i].c, vecs[i].z, vecs[i].e, vecs[i].lat);
      end
      tick();

      // WIDTH=8 full-scale multiply
      w8_in_a = 8'd255; w8_in_b = 8'd255; w8_in_op = OP_MUL; w8_in_valid = 1'b1;
      #1;
      tick();
      w8_in_valid = 1'b0;
      n = 0;
      while (!w8_out_valid && n < 40) begin tick(); n++; end
      check("w8 mul latency", 64'(n), 64'(8));
      check("w8 mul result", 64'(w8_result), 64'(65025));
      check("w8 mul flags", 64'({w8_carry, w8_zero, w8_err}), 64'(0));
      tick();

      // Backpressure: result held while out_ready is low
      in_a = 4'd1; in_b = 4'd2; in_op = OP_ADD; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp%0d result", i), 64'(result), 64'(3));
         check($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'(1));
         check($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'(0));
         tick();
      end
      in_a = 4'd6; in_b = 4'd3; in_op = OP_XOR; in_valid = 1'b1;
      #1;
      check("bp pending in_ready", 64'(in_ready), 64'(0));
      tick();
      check("bp pending hold", 64'(result), 64'(3));
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      check("bp xor result", 64'(result), 64'(5));
      check("bp xor out_valid", 64'(out_valid), 64'(1));
      tick();

      // Reset in the middle of a multiply
      in_a = 4'd9; in_b = 4'd7; in_op = OP_MUL; in_valid = 1'b1;
      #1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      #2 reset_n = 1'b0;
      #1;
      check("midrst out_valid", 64'(out_valid), 64'(0));
      check("midrst result", 64'(result), 64'(0));
      check("midrst in_ready", 64'(in_ready), 64'(0));
      tick();
      #2 reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) cnt++;
      end
      check("midrst no output", 64'(cnt), 64'(0));
      run_vec("postrst add", 4'd2, 4'd2, 3'd0, 4, 0, 0, 0, 0);
      tick();

      // Randomized stream against the reference model
      out_ready = 1'b1; in_valid = 1'b0;
      tick(); tick();
      hold_in = 0; prev_hold = 0; prev_res = '0; prev_flags = '0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         if (prev_hold) begin
            check("rand hold result", 64'(result), 64'(prev_res));
            check("rand hold flags", 64'({out_valid, carry, zero, err}), 64'(prev_flags));
         end
         if (cyc >= 400) begin
            in_valid = 1'b0;
            out_ready = 1'b1;
         end else begin
            if (!hold_in) begin
               in_valid = 1'($urandom_range(0, 1));
               in_a     = 4'($urandom_range(0, 15));
               in_b     = 4'($urandom_range(0, 15));
               in_op    = opcode_t'(3'($urandom_range(0, 7)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
         end
         #1;
         acc = in_valid && in_ready;
         deq = out_valid && out_ready;
         if (deq) begin
            if (q.size() == 0) begin
               check("rand unexpected output", 64'(1), 64'(0));
            end else begin
               f = q.pop_front();
               check("rand result", 64'(result), 64'(f.r));
               check("rand flags", 64'({carry, zero, err}), 64'({f.c, f.z, f.e}));
            end
         end
         if (acc) begin
            x = model(in_a, in_b, in_op, 4);
            q.push_back(x);
         end
         hold_in    = in_valid && !acc;
         prev_hold  = out_valid && !out_ready;
         prev_res   = result;
         prev_flags = {out_valid, carry, zero, err};
         tick();
      end
      check("rand drained", 64'(q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
